// File: rtl/counter_pkg.sv
// Shared types and constants for the modulo up/down counter family.
// The bound helper is used by both the counter and its property checker.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam int CNT_MAX_WIDTH = 64;

    // Largest reachable count for a given width and modulus (0 = full range).
    function automatic longint unsigned max_val(
        input int              width,
        input longint unsigned modulus
    );
        if (modulus != 64'd0) begin
            return modulus - 64'd1;
        end
        if (width >= CNT_MAX_WIDTH) begin
            return '1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/counter_mod_props.sv
// Property checker for counter_mod, attached with bind.
// Compares each cycle against the inputs sampled on the previous edge.
import counter_pkg::*;

module counter_mod_props #(
    parameter int              WIDTH   = 64,
    parameter longint unsigned MODULUS = 0,
    parameter cnt_mode_e       MODE    = CNT_WRAP,
    parameter longint unsigned RST_VAL = 0
) (
    input logic             clk,
    input logic             rst,
    input logic             en,
    input logic             up,
    input logic             load,
    input logic [WIDTH-1:0] load_val,
    input logic [WIDTH-1:0] y,
    input logic             tc,
    input logic             wrapped,
    input logic             at_bound
);

    localparam logic [WIDTH-1:0] MAX  = WIDTH'(max_val(WIDTH, MODULUS));
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RST_VAL);
    localparam logic             SAT  = (MODE == CNT_SAT);

    logic             r_past_valid;
    logic             r_en;
    logic             r_up;
    logic             r_load;
    logic [WIDTH-1:0] r_load_val;
    logic [WIDTH-1:0] r_y;
    logic             r_at_bound;

    logic [WIDTH-1:0] w_exp_y;
    logic             w_exp_wrapped;
    logic             w_exp_bound;
    logic             w_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_past_valid <= 1'b0;
            r_en         <= 1'b0;
            r_up         <= 1'b0;
            r_load       <= 1'b0;
            r_load_val   <= '0;
            r_y          <= '0;
            r_at_bound   <= 1'b0;
        end else begin
            r_past_valid <= 1'b1;
            r_en         <= en;
            r_up         <= up;
            r_load       <= load;
            r_load_val   <= load_val;
            r_y          <= y;
            r_at_bound   <= at_bound;
        end
    end

    always_comb begin
        w_hit         = r_up ? (r_y == MAX) : (r_y == '0);
        w_exp_y       = r_y;
        w_exp_wrapped = 1'b0;
        w_exp_bound   = r_at_bound;
        if (r_load) begin
            w_exp_y     = (r_load_val > MAX) ? MAX : r_load_val;
            w_exp_bound = 1'b0;
        end else if (r_en) begin
            w_exp_bound = SAT && w_hit;
            if (!w_hit) begin
                w_exp_y = r_up ? r_y + WIDTH'(1) : r_y - WIDTH'(1);
            end else if (!SAT) begin
                w_exp_y       = r_up ? '0 : MAX;
                w_exp_wrapped = 1'b1;
            end
        end
    end

    // Checked mid-cycle so every registered value has settled.
    always @(negedge clk) begin
        if (rst) begin
            assert (y == RSTV);
            assert (wrapped == 1'b0);
            assert (at_bound == 1'b0);
        end else if (r_past_valid) begin
            assert (y <= MAX);
            assert (y == w_exp_y);
            assert (wrapped == w_exp_wrapped);
            assert (at_bound == w_exp_bound);
            assert (!wrapped || (r_y == MAX) || (r_y == '0));
            assert (tc == (en && !load && (up ? (y == MAX) : (y == '0))));
        end
    end

endmodule

bind counter_mod counter_mod_props #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .MODE    (MODE),
    .RST_VAL (RST_VAL)
) u_props (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .y        (y),
    .tc       (tc),
    .wrapped  (wrapped),
    .at_bound (at_bound)
);

// File: rtl/counter_mod.sv
// Parametrised modulo up/down counter with load, wrap/saturate modes,
// terminal count, wrap pulse and saturation-bound flag.
import counter_pkg::*;

module counter_mod #(
    parameter int              WIDTH   = 64,
    parameter longint unsigned MODULUS = 0,
    parameter cnt_mode_e       MODE    = CNT_WRAP,
    parameter longint unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             wrapped,
    output logic             at_bound
);

    localparam longint unsigned MAX64 = max_val(WIDTH, MODULUS);
    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MAX64);
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RST_VAL);
    localparam logic             SAT  = (MODE == CNT_SAT);

    if (WIDTH < 1 || WIDTH > CNT_MAX_WIDTH) begin : g_bad_width
        $error("counter_mod: WIDTH must be 1..64");
    end
    if (!(MODULUS == 64'd0 || (MODULUS >= 64'd2 &&
          (WIDTH >= CNT_MAX_WIDTH || MODULUS < (64'd1 << WIDTH)))))
    begin : g_bad_modulus
        $error("counter_mod: MODULUS must be 0 or 2..2**WIDTH-1");
    end
    if (RST_VAL >= MAX64) begin : g_bad_rst_val
        $error("counter_mod: RST_VAL must be below MAX");
    end

    logic [WIDTH-1:0] r_y;
    logic             r_wrapped;
    logic             r_at_bound;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_hit;
    logic [WIDTH-1:0] w_y_nxt;
    logic             w_wrapped_nxt;
    logic             w_bound_nxt;

    assign w_at_max  = (r_y == MAX);
    assign w_at_zero = (r_y == '0);
    assign w_hit     = up ? w_at_max : w_at_zero;

    always_comb begin
        w_y_nxt       = r_y;
        w_wrapped_nxt = 1'b0;
        w_bound_nxt   = r_at_bound;
        if (load) begin
            w_y_nxt     = (load_val > MAX) ? MAX : load_val;
            w_bound_nxt = 1'b0;
        end else if (en) begin
            // Leaving the bound clears the flag; pressing into it sets it.
            w_bound_nxt = SAT && w_hit;
            if (!w_hit) begin
                w_y_nxt = up ? r_y + WIDTH'(1) : r_y - WIDTH'(1);
            end else if (!SAT) begin
                w_y_nxt       = up ? '0 : MAX;
                w_wrapped_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y        <= RSTV;
            r_wrapped  <= 1'b0;
            r_at_bound <= 1'b0;
        end else begin
            r_y        <= w_y_nxt;
            r_wrapped  <= w_wrapped_nxt;
            r_at_bound <= w_bound_nxt;
        end
    end

    assign y        = r_y;
    assign wrapped  = r_wrapped;
    assign at_bound = r_at_bound;
    assign tc       = en & ~load & w_hit;

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod: wrap, saturate and full-range instances.
// Expected values are hand-derived per step.
import counter_pkg::*;

module tb_counter_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a_en, a_up, a_load;
    logic [3:0] a_lv, a_y;
    logic       a_tc, a_wr, a_ab;

    logic       b_en, b_up, b_load;
    logic [3:0] b_lv, b_y;
    logic       b_tc, b_wr, b_ab;

    logic        c_en, c_up, c_load;
    logic [63:0] c_lv, c_y;
    logic        c_tc, c_wr, c_ab;

    int checks = 0;
    int errors = 0;

    counter_mod #(
        .WIDTH(4), .MODULUS(10), .MODE(CNT_WRAP), .RST_VAL(0)
    ) u_a (
        .clk(clk), .rst(rst), .en(a_en), .up(a_up), .load(a_load),
        .load_val(a_lv), .y(a_y), .tc(a_tc), .wrapped(a_wr),
        .at_bound(a_ab)
    );

    counter_mod #(
        .WIDTH(4), .MODULUS(10), .MODE(CNT_SAT), .RST_VAL(0)
    ) u_b (
        .clk(clk), .rst(rst), .en(b_en), .up(b_up), .load(b_load),
        .load_val(b_lv), .y(b_y), .tc(b_tc), .wrapped(b_wr),
        .at_bound(b_ab)
    );

    counter_mod #(
        .WIDTH(64), .MODULUS(0), .MODE(CNT_WRAP), .RST_VAL(0)
    ) u_c (
        .clk(clk), .rst(rst), .en(c_en), .up(c_up), .load(c_load),
        .load_val(c_lv), .y(c_y), .tc(c_tc), .wrapped(c_wr),
        .at_bound(c_ab)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        a_en = 0; a_up = 1; a_load = 0; a_lv = '0;
        b_en = 0; b_up = 1; b_load = 0; b_lv = '0;
        c_en = 0; c_up = 1; c_load = 0; c_lv = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_a_y", a_y, 0);
        chk("rst_a_wr", a_wr, 0);
        chk("rst_a_ab", a_ab, 0);
        chk("rst_b_y", b_y, 0);
        chk("rst_c_y", c_y, 0);
        tick;
        tick;
        rst = 1'b0;

        // Reset mid-count
        a_load = 1; a_lv = 4'd5;
        tick;
        chk("load5", a_y, 5);
        a_load = 0; a_en = 1; a_up = 1;
        tick;
        tick;
        chk("count7", a_y, 7);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_y", a_y, 0);
        chk("rst_mid_wr", a_wr, 0);
        #1 rst = 1'b0;
        tick;
        chk("resume", a_y, 1);

        // WRAP up
        a_load = 1; a_lv = 4'd8;
        tick;
        chk("load8", a_y, 8);
        a_load = 0;
        tick;
        chk("up_y9", a_y, 9);
        chk("up_tc", a_tc, 1);
        tick;
        chk("up_wrap_y", a_y, 0);
        chk("up_wrap_pulse", a_wr, 1);
        chk("up_tc_off", a_tc, 0);
        tick;
        chk("up_y1", a_y, 1);
        chk("up_wr_drop", a_wr, 0);

        // WRAP down
        a_up = 0;
        #1;
        chk("dn_tc_y1", a_tc, 0);
        tick;
        chk("dn_y0", a_y, 0);
        chk("dn_tc", a_tc, 1);
        tick;
        chk("dn_wrap_y", a_y, 9);
        chk("dn_wrap_pulse", a_wr, 1);
        chk("dn_ab_wrapmode", a_ab, 0);
        tick;
        chk("dn_y8", a_y, 8);
        chk("dn_wr_drop", a_wr, 0);

        // Load clamp, load priority over count
        a_load = 1; a_lv = 4'd13; a_up = 1;
        #1;
        chk("load_tc_mask", a_tc, 0);
        tick;
        chk("clamp13", a_y, 9);
        chk("clamp_wr", a_wr, 0);
        a_lv = 4'd4;
        tick;
        chk("load4", a_y, 4);
        chk("load_no_wrap", a_wr, 0);
        a_load = 0; a_en = 0;
        tick;
        chk("hold4", a_y, 4);

        // SAT mode
        b_load = 1; b_lv = 4'd8; b_en = 1;
        tick;
        b_load = 0; b_up = 1;
        tick;
        chk("sat_y9a", b_y, 9);
        chk("sat_ab_a", b_ab, 0);
        chk("sat_tc", b_tc, 1);
        tick;
        chk("sat_y9b", b_y, 9);
        chk("sat_ab_b", b_ab, 1);
        tick;
        chk("sat_y9c", b_y, 9);
        chk("sat_ab_c", b_ab, 1);
        chk("sat_no_wrap", b_wr, 0);
        b_up = 0;
        tick;
        chk("sat_rev_y", b_y, 8);
        chk("sat_rev_ab", b_ab, 0);
        b_load = 1; b_lv = 4'd0;
        tick;
        b_load = 0;
        tick;
        chk("sat_lo_y", b_y, 0);
        chk("sat_lo_ab", b_ab, 1);
        b_en = 0;
        tick;
        chk("sat_hold_ab", b_ab, 1);
        b_load = 1; b_lv = 4'd3;
        tick;
        chk("sat_load_ab", b_ab, 0);
        chk("sat_load_y", b_y, 3);

        // Full range
        c_load = 1; c_lv = 64'hFFFF_FFFF_FFFF_FFFF; c_en = 1; c_up = 1;
        tick;
        chk("full_load", c_y, 64'hFFFF_FFFF_FFFF_FFFF);
        c_load = 0;
        #1;
        chk("full_tc", c_tc, 1);
        tick;
        chk("full_wrap_y", c_y, 0);
        chk("full_wrap_pulse", c_wr, 1);
        c_en = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("full_hold_y", c_y, 0);
            chk("full_hold_wr", c_wr, 0);
        end
        c_en = 1; c_up = 0;
        tick;
        chk("full_dn_y", c_y, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("full_dn_wr", c_wr, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
